// File: rtl/aes_cipher_core_pkg.sv
// Shared AES helpers: round-count constants, FSM encoding and the linear round transforms.
// Byte i of a 128-bit block sits at [127-8i -: 8]; column c holds bytes 4c..4c+3.
package aes_cipher_core_pkg;

    localparam int NR_AES256 = 14;
    localparam int NR_AES128 = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates left by r bytes: out(r,c) = in(r,(c+r) mod 4).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_cipher_core_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Also the SubWord primitive of the key schedule.
module aes_cipher_core_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Entry 0 is the leftmost byte of the concatenation.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES encryption core: one full round per incoming round key, no backpressure on keys.
// Watchdog aborts a block when the key stream stalls for TIMEOUT_CYCLES cycles (0 disables it).
module aes_cipher_core
    import aes_cipher_core_pkg::*;
#(
    parameter int NR             = NR_AES256,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [127:0] plaintext_i,
    output logic         ready_o,
    output logic         key_advance_o,
    input  logic [127:0] round_key_i,
    input  logic         round_key_valid_i,
    output logic [127:0] ciphertext_o,
    output logic         ct_valid_o,
    output logic         err_o
);

    localparam int              WDOG_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              WDOG_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [WDOG_W-1:0] WDOG_LAST =
        WDOG_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [3:0]      LAST_ROUND = 4'(NR);

    fsm_e              fsm_q, fsm_d;
    logic [127:0]      state_q, state_d;
    logic [127:0]      ct_q, ct_d;
    logic [3:0]        round_q, round_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              key_adv_q, key_adv_d;
    logic              ct_valid_q, ct_valid_d;
    logic              err_q, err_d;

    logic [127:0]      sub_bytes;
    logic [127:0]      shifted;
    logic [127:0]      mixed;
    logic              wdog_expire;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_cipher_core_sbox u_sbox (
            .in_i  (state_q[127-8*i -: 8]),
            .out_o (sub_bytes[127-8*i -: 8])
        );
    end

    assign shifted = shift_rows(sub_bytes);
    assign mixed   = mix_columns(shifted);

    // The edge that would push the idle count to TIMEOUT_CYCLES is the abort edge.
    assign wdog_expire = WDOG_EN && (fsm_q == ST_RUN) && !round_key_valid_i
                         && (wdog_q == WDOG_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: if (start_i) fsm_d = ST_RUN;
            ST_RUN: begin
                if ((round_key_valid_i && (round_q == LAST_ROUND)) || wdog_expire) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ct_d       = ct_q;
        round_d    = round_q;
        wdog_d     = wdog_q;
        key_adv_d  = 1'b0;
        ct_valid_d = 1'b0;
        err_d      = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = plaintext_i;
                    round_d   = '0;
                    wdog_d    = '0;
                    key_adv_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (round_key_valid_i) begin
                    round_d = round_q + 4'd1;
                    wdog_d  = '0;
                    if (round_q == 4'd0) begin
                        state_d = state_q ^ round_key_i;
                    end else if (round_q == LAST_ROUND) begin
                        ct_d       = shifted ^ round_key_i;
                        ct_valid_d = 1'b1;
                    end else begin
                        state_d = mixed ^ round_key_i;
                    end
                end else if (WDOG_EN) begin
                    wdog_d = wdog_q + WDOG_W'(1);
                    err_d  = wdog_expire;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= '0;
            ct_q       <= '0;
            round_q    <= '0;
            wdog_q     <= '0;
            key_adv_q  <= 1'b0;
            ct_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ct_q       <= ct_d;
            round_q    <= round_d;
            wdog_q     <= wdog_d;
            key_adv_q  <= key_adv_d;
            ct_valid_q <= ct_valid_d;
            err_q      <= err_d;
        end
    end

    assign ready_o       = (fsm_q == ST_IDLE);
    assign key_advance_o = key_adv_q;
    assign ciphertext_o  = ct_q;
    assign ct_valid_o    = ct_valid_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: instance 0 is AES-256 (NR=14, timeout 64), instance 1 is AES-128
// (NR=10, timeout 8). Keys come from a stub feeder built on a bench-side key expansion.
module tb_aes_cipher_core;

    localparam logic [127:0] PT_C     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY256_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KEY128_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C3    = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_C1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [7:0]   MC_COEF [4] = '{8'h02, 8'h03, 8'h01, 8'h01};

    logic         clk = 1'b0;
    logic         rst;
    logic         start [2];
    logic [127:0] pt    [2];
    logic [127:0] rk    [2];
    logic         rkv   [2];
    logic         ready [2];
    logic         kadv  [2];
    logic [127:0] ct    [2];
    logic         ctv   [2];
    logic         err   [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sbox_m   [256];
    logic [127:0] rk_sched [2][15];

    always #5 clk = ~clk;

    aes_cipher_core #(.NR(14), .TIMEOUT_CYCLES(64)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .plaintext_i(pt[0]),
        .ready_o(ready[0]), .key_advance_o(kadv[0]), .round_key_i(rk[0]),
        .round_key_valid_i(rkv[0]), .ciphertext_o(ct[0]), .ct_valid_o(ctv[0]), .err_o(err[0])
    );

    aes_cipher_core #(.NR(10), .TIMEOUT_CYCLES(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .plaintext_i(pt[1]),
        .ready_o(ready[1]), .key_advance_o(kadv[1]), .round_key_i(rk[1]),
        .round_key_valid_i(rkv[1]), .ciphertext_o(ct[1]), .ct_valid_o(ctv[1]), .err_o(err[1])
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic expand_key(input int d, input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk_sched[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] model_encrypt(input int d, input logic [127:0] p, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] k;
        logic [127:0] o;
        k = rk_sched[d][0];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = p[127-8*(4*c+r) -: 8] ^ k[127-8*(4*c+r) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            k = rk_sched[d][rnd];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_m[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (rnd == nr) begin
                        s[r][c] = t[r][c];
                    end else begin
                        s[r][c] = 8'h00;
                        for (int j = 0; j < 4; j++) s[r][c] = s[r][c] ^ gmul(MC_COEF[(j-r+4)%4], t[j][c]);
                    end
                    s[r][c] = s[r][c] ^ k[127-8*(4*c+r) -: 8];
                end
            end
        end
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    // ---------------- stimulus drivers ----------------
    // Leaves start high; the caller decides when to drop it.
    task automatic start_block(input int d, input logic [127:0] p, output logic kadv_seen);
        @(negedge clk);
        start[d] = 1'b1;
        pt[d]    = p;
        @(negedge clk);
        kadv_seen = kadv[d];
    endtask

    // Returns on the negedge just after the last key was sampled; tallies pulses seen on the way.
    task automatic feed_keys(input int d, input int first, input int nkeys, input int min_gap,
                             input int max_gap, output int n_ctv, output int n_kadv, output int n_err);
        int gap;
        n_ctv = 0; n_kadv = 0; n_err = 0;
        for (int k = first; k < first + nkeys; k++) begin
            gap = int'($urandom_range(max_gap, min_gap));
            repeat (gap) begin
                @(negedge clk);
                n_ctv += int'(ctv[d]); n_kadv += int'(kadv[d]); n_err += int'(err[d]);
            end
            rkv[d] = 1'b1;
            rk[d]  = rk_sched[d][k];
            @(negedge clk);
            n_ctv += int'(ctv[d]); n_kadv += int'(kadv[d]); n_err += int'(err[d]);
            rkv[d] = 1'b0;
            rk[d]  = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks++; if (ready[d] !== 1'b1) begin failures++; $display("FAIL reset_ready[%0d] got=%b exp=1", d, ready[d]); end
            checks++; if (kadv[d] !== 1'b0) begin failures++; $display("FAIL reset_kadv[%0d] got=%b exp=0", d, kadv[d]); end
            checks++; if (ctv[d] !== 1'b0) begin failures++; $display("FAIL reset_ctv[%0d] got=%b exp=0", d, ctv[d]); end
            checks++; if (err[d] !== 1'b0) begin failures++; $display("FAIL reset_err[%0d] got=%b exp=0", d, err[d]); end
            checks++; if (ct[d] !== 128'h0) begin failures++; $display("FAIL reset_ct[%0d] got=%h exp=0", d, ct[d]); end
        end
    endtask

    task automatic run_known(input int d, input int nr, input logic [127:0] exp, input int min_gap,
                             input int max_gap, input string tag);
        logic ks;
        int   nc, nk, ne;
        start_block(d, PT_C, ks);
        start[d] = 1'b0;
        feed_keys(d, 0, nr + 1, min_gap, max_gap, nc, nk, ne);
        checks++; if (ks !== 1'b1) begin failures++; $display("FAIL %s_kadv got=%b exp=1", tag, ks); end
        checks++; if (ctv[d] !== 1'b1 || ready[d] !== 1'b1) begin failures++; $display("FAIL %s_latency ctv=%b ready=%b exp=1/1", tag, ctv[d], ready[d]); end
        checks++; if (nc != 1 || nk != 0 || ne != 0) begin failures++; $display("FAIL %s_pulses ctv=%0d kadv=%0d err=%0d exp=1/0/0", tag, nc, nk, ne); end
        checks++; if (ct[d] !== exp) begin failures++; $display("FAIL %s_ct got=%h exp=%h", tag, ct[d], exp); end
        @(negedge clk);
        checks++; if (ctv[d] !== 1'b0) begin failures++; $display("FAIL %s_ctv_width got=%b exp=0", tag, ctv[d]); end
    endtask

    task automatic test_fips256();
        expand_key(0, KEY256_C, 8, 14);
        checks++; if (model_encrypt(0, PT_C, 14) !== CT_C3) begin failures++; $display("FAIL model_c3 got=%h exp=%h", model_encrypt(0, PT_C, 14), CT_C3); end
        run_known(0, 14, CT_C3, 0, 0, "c3_b2b");
        run_known(0, 14, CT_C3, 1, 10, "c3_gaps");
    endtask

    task automatic test_fips128();
        expand_key(1, {KEY128_C, 128'h0}, 4, 10);
        run_known(1, 10, CT_C1, 0, 0, "c1_b2b");
        run_known(1, 10, CT_C1, 1, 7, "c1_gaps");
    endtask

    task automatic test_random();
        logic [255:0] key;
        logic [127:0] p, exp;
        logic         ks;
        int           d, nr, nc, nk, ne;
        for (int it = 0; it < 8; it++) begin
            d   = it % 2;
            nr  = (d == 0) ? 14 : 10;
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            p   = {$urandom, $urandom, $urandom, $urandom};
            expand_key(d, key, (d == 0) ? 8 : 4, nr);
            exp = model_encrypt(d, p, nr);
            start_block(d, p, ks);
            start[d] = 1'b0;
            feed_keys(d, 0, nr + 1, 0, (it < 4) ? 0 : ((d == 0) ? 10 : 7), nc, nk, ne);
            checks++; if (ct[d] !== exp || ctv[d] !== 1'b1) begin failures++; $display("FAIL rand_ct[%0d] got=%h ctv=%b exp=%h", it, ct[d], ctv[d], exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_hold_start();
        logic [255:0] key;
        logic [127:0] p1, p2;
        logic         ks;
        int           nc, nk, ne;
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        p1  = {$urandom, $urandom, $urandom, $urandom};
        p2  = {$urandom, $urandom, $urandom, $urandom};
        expand_key(0, key, 8, 14);
        start_block(0, p1, ks);
        feed_keys(0, 0, 15, 0, 2, nc, nk, ne);
        checks++; if (ks !== 1'b1 || nk != 0) begin failures++; $display("FAIL hold_kadv first=%b extra=%0d exp=1/0", ks, nk); end
        checks++; if (ctv[0] !== 1'b1 || ready[0] !== 1'b1) begin failures++; $display("FAIL hold_ready_ctv ctv=%b ready=%b exp=1/1", ctv[0], ready[0]); end
        checks++; if (ct[0] !== model_encrypt(0, p1, 14)) begin failures++; $display("FAIL hold_ct1 got=%h exp=%h", ct[0], model_encrypt(0, p1, 14)); end
        pt[0] = p2;
        @(negedge clk);
        checks++; if (kadv[0] !== 1'b1 || ready[0] !== 1'b0) begin failures++; $display("FAIL hold_second_accept kadv=%b ready=%b exp=1/0", kadv[0], ready[0]); end
        start[0] = 1'b0;
        feed_keys(0, 0, 15, 0, 3, nc, nk, ne);
        checks++; if (ct[0] !== model_encrypt(0, p2, 14) || nc != 1) begin failures++; $display("FAIL hold_ct2 got=%h ctv=%0d exp=%h/1", ct[0], nc, model_encrypt(0, p2, 14)); end
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        logic [255:0] key;
        logic [127:0] p, prev;
        logic         ks;
        int           nc, nk, ne, early_err, early_rdy, win_ctv;
        key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        expand_key(1, key, 4, 10);
        p    = {$urandom, $urandom, $urandom, $urandom};
        prev = model_encrypt(1, p, 10);
        start_block(1, p, ks);
        start[1] = 1'b0;
        feed_keys(1, 0, 11, 0, 0, nc, nk, ne);
        checks++; if (ct[1] !== prev) begin failures++; $display("FAIL wdog_pre_ct got=%h exp=%h", ct[1], prev); end
        @(negedge clk);
        start_block(1, {$urandom, $urandom, $urandom, $urandom}, ks);
        start[1] = 1'b0;
        feed_keys(1, 0, 5, 0, 0, nc, nk, ne);
        early_err = 0; early_rdy = 0; win_ctv = 0;
        repeat (7) begin
            @(negedge clk);
            early_err += int'(err[1]); early_rdy += int'(ready[1]); win_ctv += int'(ctv[1]);
        end
        @(negedge clk);
        checks++; if (early_err != 0 || early_rdy != 0) begin failures++; $display("FAIL wdog_early err=%0d ready=%0d exp=0/0", early_err, early_rdy); end
        checks++; if (err[1] !== 1'b1 || ready[1] !== 1'b1) begin failures++; $display("FAIL wdog_abort err=%b ready=%b exp=1/1", err[1], ready[1]); end
        checks++; if (ct[1] !== prev || ctv[1] !== 1'b0 || win_ctv != 0) begin failures++; $display("FAIL wdog_ct got=%h ctv=%b exp=%h/0", ct[1], ctv[1], prev); end
        @(negedge clk);
        checks++; if (err[1] !== 1'b0) begin failures++; $display("FAIL wdog_err_width got=%b exp=0", err[1]); end
        feed_keys(1, 5, 3, 0, 0, nc, nk, ne);
        checks++; if (nc != 0 || ready[1] !== 1'b1 || ct[1] !== prev) begin failures++; $display("FAIL wdog_surplus ctv=%0d ready=%b ct=%h exp=0/1/%h", nc, ready[1], ct[1], prev); end
        p = {$urandom, $urandom, $urandom, $urandom};
        start_block(1, p, ks);
        start[1] = 1'b0;
        feed_keys(1, 0, 11, 7, 7, nc, nk, ne);
        checks++; if (ne != 0 || ct[1] !== model_encrypt(1, p, 10) || ctv[1] !== 1'b1) begin failures++; $display("FAIL wdog_gap7 err=%0d ct=%h exp=0/%h", ne, ct[1], model_encrypt(1, p, 10)); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [255:0] key;
        logic [127:0] p;
        logic         ks;
        int           nc, nk, ne;
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        expand_key(0, key, 8, 14);
        start_block(0, {$urandom, $urandom, $urandom, $urandom}, ks);
        start[0] = 1'b0;
        feed_keys(0, 0, 7, 0, 1, nc, nk, ne);
        rst = 1'b1;
        #1;
        checks++; if (ready[0] !== 1'b1 || kadv[0] !== 1'b0 || ctv[0] !== 1'b0 || err[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_ctl ready=%b kadv=%b ctv=%b err=%b exp=1/0/0/0", ready[0], kadv[0], ctv[0], err[0]); end
        checks++; if (ct[0] !== 128'h0) begin failures++; $display("FAIL rst_mid_ct got=%h exp=0", ct[0]); end
        @(negedge clk);
        rst = 1'b0;
        p = {$urandom, $urandom, $urandom, $urandom};
        start_block(0, p, ks);
        start[0] = 1'b0;
        feed_keys(0, 0, 15, 0, 4, nc, nk, ne);
        checks++; if (ct[0] !== model_encrypt(0, p, 14) || nc != 1) begin failures++; $display("FAIL rst_mid_next_ct got=%h ctv=%0d exp=%h/1", ct[0], nc, model_encrypt(0, p, 14)); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; rkv[d] = 1'b0; pt[d] = '0; rk[d] = '0;
        end
        build_sbox();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_fips256();
        test_fips128();
        test_random();
        test_hold_start();
        test_watchdog();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
